digital_clock_alarm: RTL
========================

Name: digital_clock_alarm

Overview:
Parametrised next-generation time-of-day counter with:
- a prescaler, so it runs from a fast clock or directly from a 1 Hz clock;
- run/pause control;
- a validated runtime time-load handshake;
- an alarm state machine with acknowledge, snooze and auto-timeout.

It feeds the display and annunciator logic. Field limits are generic, so the same block serves 24 h or non-standard timebases.

Parameters:
TICK_DIV, 1, Clk_1sec cycles per one-second advance (1 = advance every enabled cycle)
SEC_PER_MIN, 60, seconds modulus
MIN_PER_HOUR, 60, minutes modulus
HOURS_PER_DAY, 24, hours modulus
SNOOZE_SEC, 300, seconds spent in snooze before re-ringing
RING_TIMEOUT_SEC, 60, seconds of unacknowledged ringing before auto-stop
Derived widths: SW=$clog2(SEC_PER_MIN), MW=$clog2(MIN_PER_HOUR), HW=$clog2(HOURS_PER_DAY). Defaults give 6/6/5.

Ports:
Clk_1sec  in  1  clock (1 Hz, or fast clock with TICK_DIV>1)
reset  in  1  asynchronous, active-high reset
init_seconds/init_minutes/init_hours  in  SW/MW/HW  time loaded while reset is asserted
run  in  1  1 = count, 0 = hold time (prescaler also holds)
load_valid  in  1  runtime time-load request
load_seconds/load_minutes/load_hours  in  SW/MW/HW  runtime load value
load_ready  out  1  constant 1 (load accepted in a single cycle)
load_err  out  1  one-cycle pulse when a load is rejected as out of range
alarm_en  in  1  alarm armed
alarm_hours/alarm_minutes  in  HW/MW  alarm time
alarm_ack  in  1  stop ringing
snooze  in  1  defer ringing
seconds/minutes/hours  out  SW/MW/HW  current time (registered)
sec_tick  out  1  one-cycle pulse on each advance
day_tick  out  1  one-cycle pulse when hours wrap to 0
alarm_out  out  1  high while in RING

Behaviour:
- Reset (asynchronous):
  - seconds/minutes/hours take init_*;
  - prescaler, ring counter and snooze counter clear to 0;
  - alarm FSM goes to IDLE;
  - all pulses and alarm_out are 0.
- Prescaler:
  - div_cnt counts 0..TICK_DIV-1 while run=1.
  - adv=1 when run=1 and div_cnt==TICK_DIV-1; div_cnt then returns to 0.
  - With TICK_DIV=1, adv=run.
- Advance:
  - On adv, seconds increments. seconds>=SEC_PER_MIN-1 wraps it to 0 and carries into minutes.
  - Minutes wrap the same way at MIN_PER_HOUR-1 and carry into hours.
  - Hours wrap at HOURS_PER_DAY-1, which also sets day_tick.
  - The >= compare makes out-of-range init values wrap to 0 on the first advance, never run away.
  - sec_tick equals registered adv.
- Load:
  - load_valid=1 with all load fields in range (sec<SEC_PER_MIN, min<MIN_PER_HOUR, hr<HOURS_PER_DAY) writes all three fields next edge and clears div_cnt.
  - Load has priority over a coincident adv: the advance is dropped, with no sec_tick and no day_tick.
  - An out-of-range load leaves time unchanged and pulses load_err.
- Alarm FSM:
  - States IDLE, RING, SNOOZE. alarm_en=0 forces IDLE from any state.
  - IDLE->RING: on adv, when the post-advance time equals alarm_hours:alarm_minutes:00.
  - IDLE->RING is also taken when a valid load lands exactly on that time.
  - RING->IDLE: on alarm_ack, or after RING_TIMEOUT_SEC advances.
  - RING->SNOOZE: on snooze, only when alarm_ack=0; ack wins if both are asserted.
  - SNOOZE->RING: after SNOOZE_SEC advances. alarm_ack in SNOOZE -> IDLE.
  - Counters clear on every state entry. alarm_out is registered: high the cycle after entering RING.
  - run=0 freezes the ring and snooze counters, since they count only on adv.
- Reset mid-ring or mid-load: the asynchronous reset overrides everything; no pulse is emitted in the reset cycle.

Decomposition:
- Shared package clock_pkg holds:
  - alarm_state_t enum {IDLE, RING, SNOOZE};
  - default modulus constants (60/60/24).
- One sub-module is natural: mod_counter, a generic modulo counter with inc/load/carry, instantiated three times for the seconds/minutes/hours chain.
- Prescaler and alarm FSM stay in the top level.

Test Plan:
1. Defaults, init 23:59:58, run=1 for 3 cycles -> 23:59:59, 00:00:00 with day_tick=1 in that cycle, then 00:00:01.
2. TICK_DIV=4, init 00:00:00, run=1 for 12 cycles -> seconds=3 and 3 sec_tick pulses; run=0 for 10 cycles -> unchanged.
3. Load 12:34:56 coincident with adv -> time reads 12:34:56, no sec_tick. Load 12:60:00 -> load_err pulse, time unchanged.
4. Alarm 07:00, time 06:59:59, advance once -> alarm_out=1 next cycle. With no ack, it drops after 60 advances.
5. Ringing, snooze=1 -> alarm_out=0. After 300 advances -> alarm_out=1. Then alarm_ack and snooze in the same cycle -> IDLE.
6. Reset asserted asynchronously while ringing at 07:00:10 -> alarm_out=0 and time=init immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clock_pkg.sv
//==============================================================================
// Module : clock_pkg
// Purpose: Shared types and default timebase constants for the time-of-day
//          counter and alarm block.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package clock_pkg;

  // Alarm controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  // Default field moduli for a standard 24 h clock
  localparam int C_DEF_SEC_PER_MIN   = 60;
  localparam int C_DEF_MIN_PER_HOUR  = 60;
  localparam int C_DEF_HOURS_PER_DAY = 24;

endpackage

`default_nettype wire

// File: rtl/digital_clock_alarm_mod_counter.sv
//==============================================================================
// Module : mod_counter
// Purpose: Generic modulo counter used for each field of the time chain.
//          Increments on i_inc, wraps to 0 at MOD-1 (or above) and flags a
//          carry in the same cycle; i_load overrides the increment.
// Ports  : Clk_1sec   - clock
//          reset      - asynchronous active-high reset, loads i_init_val
//          i_init_val - value taken while reset is asserted
//          i_inc      - increment request
//          i_load     - synchronous load request (priority over i_inc)
//          i_load_val - value written by i_load
//          o_count    - current count (registered)
//          o_carry    - combinational: i_inc and the count is about to wrap
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = $clog2(MOD)
) (
  input  logic         Clk_1sec,
  input  logic         reset,
  input  logic [W-1:0] i_init_val,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_carry
);

  localparam logic [W-1:0] C_MAX = W'(MOD - 1);

  // ">=" rather than "==" so an out-of-range init value wraps on the first
  // increment instead of running through the unused codes.
  assign o_carry = i_inc && (o_count >= C_MAX);

  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      o_count <= i_init_val;
    end else if (i_load) begin
      o_count <= i_load_val;
    end else if (i_inc) begin
      o_count <= o_carry ? '0 : o_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/digital_clock_alarm.sv
//==============================================================================
// Module : digital_clock_alarm
// Purpose: Time-of-day counter with prescaler, run/pause, validated runtime
//          load and an alarm controller (ring / snooze / acknowledge /
//          auto-timeout).
// Ports  : Clk_1sec, reset            - clock, async active-high reset
//          init_seconds/minutes/hours - time taken while reset is high
//          run                        - 1 = count, 0 = hold (prescaler too)
//          load_valid, load_*         - runtime time load request/value
//          load_ready                 - always 1
//          load_err                   - pulse on an out-of-range load
//          alarm_en, alarm_hours/min  - alarm arming and time
//          alarm_ack, snooze          - stop / defer ringing
//          seconds/minutes/hours      - current time
//          sec_tick, day_tick         - advance / midnight wrap pulses
//          alarm_out                  - high while ringing
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module digital_clock_alarm
  import clock_pkg::*;
#(
  parameter int TICK_DIV         = 1,
  parameter int SEC_PER_MIN      = C_DEF_SEC_PER_MIN,
  parameter int MIN_PER_HOUR     = C_DEF_MIN_PER_HOUR,
  parameter int HOURS_PER_DAY    = C_DEF_HOURS_PER_DAY,
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic                             Clk_1sec,
  input  logic                             reset,
  input  logic [$clog2(SEC_PER_MIN)-1:0]   init_seconds,
  input  logic [$clog2(MIN_PER_HOUR)-1:0]  init_minutes,
  input  logic [$clog2(HOURS_PER_DAY)-1:0] init_hours,
  input  logic                             run,
  input  logic                             load_valid,
  input  logic [$clog2(SEC_PER_MIN)-1:0]   load_seconds,
  input  logic [$clog2(MIN_PER_HOUR)-1:0]  load_minutes,
  input  logic [$clog2(HOURS_PER_DAY)-1:0] load_hours,
  output logic                             load_ready,
  output logic                             load_err,
  input  logic                             alarm_en,
  input  logic [$clog2(HOURS_PER_DAY)-1:0] alarm_hours,
  input  logic [$clog2(MIN_PER_HOUR)-1:0]  alarm_minutes,
  input  logic                             alarm_ack,
  input  logic                             snooze,
  output logic [$clog2(SEC_PER_MIN)-1:0]   seconds,
  output logic [$clog2(MIN_PER_HOUR)-1:0]  minutes,
  output logic [$clog2(HOURS_PER_DAY)-1:0] hours,
  output logic                             sec_tick,
  output logic                             day_tick,
  output logic                             alarm_out
);

  localparam int SW = $clog2(SEC_PER_MIN);
  localparam int MW = $clog2(MIN_PER_HOUR);
  localparam int HW = $clog2(HOURS_PER_DAY);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam int ZW = $clog2(SNOOZE_SEC + 1);

  localparam logic [DW-1:0] C_DIV_MAX  = DW'(TICK_DIV - 1);
  localparam logic [RW-1:0] C_RING_MAX = RW'(RING_TIMEOUT_SEC - 1);
  localparam logic [ZW-1:0] C_SNZ_MAX  = ZW'(SNOOZE_SEC - 1);
  // One extra bit so a modulus equal to 2**W still compares correctly
  localparam logic [SW:0]   C_SEC_LIM  = (SW+1)'(SEC_PER_MIN);
  localparam logic [MW:0]   C_MIN_LIM  = (MW+1)'(MIN_PER_HOUR);
  localparam logic [HW:0]   C_HR_LIM   = (HW+1)'(HOURS_PER_DAY);

  logic [DW-1:0] r_div_cnt;
  logic [RW-1:0] r_ring_cnt;
  logic [ZW-1:0] r_snz_cnt;
  alarm_state_t  r_state;

  logic          w_adv;
  logic          w_adv_eff;
  logic          w_load_ok;
  logic          w_carry_s;
  logic          w_carry_m;
  logic          w_carry_h;
  logic [MW-1:0] w_next_min;
  logic [HW-1:0] w_next_hr;
  logic          w_adv_hit;
  logic          w_load_hit;

  assign load_ready = 1'b1;

  assign w_load_ok = load_valid
                   && ({1'b0, load_seconds} < C_SEC_LIM)
                   && ({1'b0, load_minutes} < C_MIN_LIM)
                   && ({1'b0, load_hours}   < C_HR_LIM);

  assign w_adv     = run && (r_div_cnt == C_DIV_MAX);
  // A valid load wins over a coincident advance; the advance is lost
  assign w_adv_eff = w_adv && !w_load_ok;

  //--------------------------------------------------------------------------
  // Prescaler
  //--------------------------------------------------------------------------
  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_load_ok) begin
      r_div_cnt <= '0;
    end else if (run) begin
      r_div_cnt <= w_adv ? '0 : r_div_cnt + 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Seconds -> minutes -> hours chain
  //--------------------------------------------------------------------------
  mod_counter #(.MOD(SEC_PER_MIN), .W(SW)) u_sec (
    .Clk_1sec   (Clk_1sec),
    .reset      (reset),
    .i_init_val (init_seconds),
    .i_inc      (w_adv_eff),
    .i_load     (w_load_ok),
    .i_load_val (load_seconds),
    .o_count    (seconds),
    .o_carry    (w_carry_s)
  );

  mod_counter #(.MOD(MIN_PER_HOUR), .W(MW)) u_min (
    .Clk_1sec   (Clk_1sec),
    .reset      (reset),
    .i_init_val (init_minutes),
    .i_inc      (w_carry_s),
    .i_load     (w_load_ok),
    .i_load_val (load_minutes),
    .o_count    (minutes),
    .o_carry    (w_carry_m)
  );

  mod_counter #(.MOD(HOURS_PER_DAY), .W(HW)) u_hr (
    .Clk_1sec   (Clk_1sec),
    .reset      (reset),
    .i_init_val (init_hours),
    .i_inc      (w_carry_m),
    .i_load     (w_load_ok),
    .i_load_val (load_hours),
    .o_count    (hours),
    .o_carry    (w_carry_h)
  );

  //--------------------------------------------------------------------------
  // Pulses
  //--------------------------------------------------------------------------
  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= w_adv_eff;
      day_tick <= w_carry_h;
      load_err <= load_valid && !w_load_ok;
    end
  end

  //--------------------------------------------------------------------------
  // Alarm match. The post-advance time is hh:mm:00 exactly when seconds
  // carries, so only minutes and hours need their next values.
  //--------------------------------------------------------------------------
  assign w_next_min = w_carry_m ? '0 : (w_carry_s ? minutes + 1'b1 : minutes);
  assign w_next_hr  = w_carry_h ? '0 : (w_carry_m ? hours + 1'b1 : hours);

  assign w_adv_hit  = w_adv_eff && w_carry_s
                    && (w_next_min == alarm_minutes)
                    && (w_next_hr  == alarm_hours);
  assign w_load_hit = w_load_ok && (load_seconds == '0)
                    && (load_minutes == alarm_minutes)
                    && (load_hours   == alarm_hours);

  //--------------------------------------------------------------------------
  // Alarm controller. Both counters are cleared on every transition so each
  // state always starts counting from zero.
  //--------------------------------------------------------------------------
  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      alarm_out  <= 1'b0;
    end else if (!alarm_en) begin
      r_state    <= IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      alarm_out  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_adv_hit || w_load_hit) begin
            r_state    <= RING;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            alarm_out  <= 1'b1;
          end
        end
        RING: begin
          if (alarm_ack) begin
            r_state    <= IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            alarm_out  <= 1'b0;
          end else if (snooze) begin
            r_state    <= SNOOZE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            alarm_out  <= 1'b0;
          end else if (w_adv_eff) begin
            if (r_ring_cnt == C_RING_MAX) begin
              r_state    <= IDLE;
              r_ring_cnt <= '0;
              r_snz_cnt  <= '0;
              alarm_out  <= 1'b0;
            end else begin
              r_ring_cnt <= r_ring_cnt + 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (alarm_ack) begin
            r_state    <= IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            alarm_out  <= 1'b0;
          end else if (w_adv_eff) begin
            if (r_snz_cnt == C_SNZ_MAX) begin
              r_state    <= RING;
              r_ring_cnt <= '0;
              r_snz_cnt  <= '0;
              alarm_out  <= 1'b1;
            end else begin
              r_snz_cnt <= r_snz_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ring_cnt <= '0;
          r_snz_cnt  <= '0;
          alarm_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
